glitch_sweep_sched: RTL

//  Sweep scheduler for the glitch pulse generator. Steps a (delay, width) grid, one point per attempt.

---
 rtl/glitch_sweep_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/glitch_sweep_sched.sv
// Sweep scheduler stepping a (delay, width) grid, one glitch attempt per point.
// Optional build macro GLITCH_SWEEP_STOP_ON_HIT_EN ends the sweep on the first fault.
module glitch_sweep_sched #(
   parameter int DELAY_W    = 32,
   parameter int WIDTH_W    = 16,
   parameter int DELAY_MIN  = 10,
   parameter int DELAY_MAX  = 12,
   parameter int DELAY_STEP = 1,
   parameter int WIDTH_MIN  = 2,
   parameter int WIDTH_MAX  = 3,
   parameter int WIDTH_STEP = 1,
   parameter int COOLDOWN   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sweep_start,
   input  logic               sweep_abort,
   input  logic               target_trigger,
   input  logic               target_fault,
   input  logic               gen_done,
   output logic               gen_start,
   output logic [DELAY_W-1:0] glitch_delay,
   output logic [WIDTH_W-1:0] glitch_width,
   output logic               arm,
   output logic               busy,
   output logic               sweep_done,
   output logic               hit,
   output logic [DELAY_W-1:0] hit_delay,
   output logic [WIDTH_W-1:0] hit_width,
   output logic [15:0]        attempt_count
);

   localparam logic [DELAY_W-1:0] D_MIN_V  = DELAY_W'(DELAY_MIN);
   localparam logic [DELAY_W:0]   D_MAX_X  = (DELAY_W+1)'(DELAY_MAX);
   localparam logic [DELAY_W:0]   D_STEP_X = (DELAY_W+1)'(DELAY_STEP);
   localparam logic [WIDTH_W-1:0] W_MIN_V  = WIDTH_W'(WIDTH_MIN);
   localparam logic [WIDTH_W:0]   W_MAX_X  = (WIDTH_W+1)'(WIDTH_MAX);
   localparam logic [WIDTH_W:0]   W_STEP_X = (WIDTH_W+1)'(WIDTH_STEP);
   localparam int                 CNT_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(COOLDOWN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_FIRE,
      S_WAIT_DONE,
      S_COOLDOWN,
      S_STEP,
      S_FINISH
   } state_t;

   state_t             state;
   logic               trig_prev;
   logic               fire_q;
   logic [CNT_W-1:0]   cool_cnt;
   logic [WIDTH_W:0]   width_inc;
   logic [DELAY_W:0]   delay_inc;

   // One bit of headroom so the overflow test can never wrap back into range.
   assign width_inc = {1'b0, glitch_width} + W_STEP_X;
   assign delay_inc = {1'b0, glitch_delay} + D_STEP_X;

   // An abort arriving in the fire cycle must still keep the strobe off the generator.
   assign gen_start = fire_q & ~sweep_abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         trig_prev     <= 1'b0;
         fire_q        <= 1'b0;
         cool_cnt      <= '0;
         arm           <= 1'b0;
         busy          <= 1'b0;
         sweep_done    <= 1'b0;
         hit           <= 1'b0;
         hit_delay     <= '0;
         hit_width     <= '0;
         attempt_count <= '0;
         glitch_delay  <= D_MIN_V;
         glitch_width  <= W_MIN_V;
      end else begin
         trig_prev <= target_trigger;
         if (sweep_abort) begin
            state      <= S_IDLE;
            fire_q     <= 1'b0;
            arm        <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (sweep_start) begin
                     glitch_delay  <= D_MIN_V;
                     glitch_width  <= W_MIN_V;
                     hit           <= 1'b0;
                     hit_delay     <= '0;
                     hit_width     <= '0;
                     attempt_count <= '0;
                     busy          <= 1'b1;
                     arm           <= 1'b1;
                     state         <= S_ARM;
                  end
               end
               S_ARM: begin
                  if (target_trigger && !trig_prev) begin
                     arm    <= 1'b0;
                     fire_q <= 1'b1;
                     state  <= S_FIRE;
                  end
               end
               S_FIRE: begin
                  fire_q <= 1'b0;
                  state  <= S_WAIT_DONE;
               end
               S_WAIT_DONE: begin
                  if (gen_done) begin
                     cool_cnt <= '0;
                     state    <= S_COOLDOWN;
                  end
               end
               S_COOLDOWN: begin
                  if (cool_cnt == CNT_LAST) begin
                     if (target_fault && !hit) begin
                        hit       <= 1'b1;
                        hit_delay <= glitch_delay;
                        hit_width <= glitch_width;
                     end
`ifdef GLITCH_SWEEP_STOP_ON_HIT_EN
                     if (target_fault) begin
                        if (attempt_count != 16'hFFFF)
                           attempt_count <= attempt_count + 16'd1;
                        sweep_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_FINISH;
                     end else begin
                        state <= S_STEP;
                     end
`else
                     state <= S_STEP;
`endif
                  end else begin
                     cool_cnt <= cool_cnt + 1'b1;
                  end
               end
               S_STEP: begin
                  if (attempt_count != 16'hFFFF)
                     attempt_count <= attempt_count + 16'd1;
                  // Width is the inner loop; the last grid point is kept on finish.
                  if (width_inc > W_MAX_X) begin
                     if (delay_inc > D_MAX_X) begin
                        sweep_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_FINISH;
                     end else begin
                        glitch_delay <= delay_inc[DELAY_W-1:0];
                        glitch_width <= W_MIN_V;
                        arm          <= 1'b1;
                        state        <= S_ARM;
                     end
                  end else begin
                     glitch_width <= width_inc[WIDTH_W-1:0];
                     arm          <= 1'b1;
                     state        <= S_ARM;
                  end
               end
               S_FINISH: begin
                  sweep_done <= 1'b0;
                  state      <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
